// File: rtl/vid_pattern_gen_pkg.sv
// Shared video types for the pattern generator: FSM states, pattern
// encodings, latched-config payload and the blank-length helper.
package vid_pattern_gen_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FRAME_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_DIAG  = 2'd3
    } pat_sel_e;

    // Frame configuration captured at frame start.
    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] height;
        logic [CNT_W-1:0] hblank;
        logic [CNT_W-1:0] vblank;
        pat_sel_e         pat;
    } vid_cfg_t;

    // Down-counter load for a blank of max(len,1) cycles.
    function automatic logic [CNT_W-1:0] blank_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Video output bundle of the pattern generator.
//   do_o         pixel data
//   de_o         pixel valid
//   hs_o         high outside the active line
//   vs_o         high outside the active frame
//   frame_done_o one-cycle pulse at the end of each frame
interface vid_pattern_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] do_o;
    logic                  de_o;
    logic                  hs_o;
    logic                  vs_o;
    logic                  frame_done_o;

    modport master (output do_o, de_o, hs_o, vs_o, frame_done_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o, frame_done_o);
endinterface

// File: rtl/vid_pattern_lut.sv
// Combinational pixel generator.
//   sel   pattern select
//   x, y  slot and line counters
//   f     frame counter
//   pix_c pixel value, truncated to DATA_WIDTH
module vid_pattern_lut
    import vid_pattern_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  pat_sel_e               sel,
    input  logic [CNT_W-1:0]       x,
    input  logic [CNT_W-1:0]       y,
    input  logic [FRAME_W-1:0]     f,
    output logic [DATA_WIDTH-1:0]  pix_c
);

    logic [CNT_W-1:0] diag;

    assign diag = x + y + CNT_W'(f);

    always_comb begin
        pix_c = '0;
        case (sel)
            PAT_HRAMP: pix_c = DATA_WIDTH'(x);
            PAT_VRAMP: pix_c = DATA_WIDTH'(y);
            PAT_CHECK: pix_c = (x[3] ^ y[3]) ? '1 : '0;
            PAT_DIAG:  pix_c = DATA_WIDTH'(diag);
            default:   pix_c = '0;
        endcase
    end

endmodule

// File: rtl/vid_pattern_gen.sv
// Video test-pattern generator: frame/line timing FSM, x/y/frame counters
// and registered video outputs.
//   clk, rst        clock, asynchronous active-low reset
//   enable_i        run request
//   cfg_*_i         width, height, hblank, vblank (latched at frame start)
//   pattern_sel_i   pattern select (latched at frame start)
//   vid             video output bundle (do/de/hs/vs/frame_done)
module vid_pattern_gen
    import vid_pattern_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SPARSE_OUTPUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  cfg_width_i,
    input  logic [CNT_W-1:0]  cfg_height_i,
    input  logic [CNT_W-1:0]  cfg_hblank_i,
    input  logic [CNT_W-1:0]  cfg_vblank_i,
    input  logic [1:0]        pattern_sel_i,
    vid_pattern_gen_if.master vid
);

    localparam int unsigned SUB_W = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SPARSE_OUTPUT);

    state_e                 state_q, state_n;
    vid_cfg_t               cfg_q, cfg_n, cfg_in_c;
    logic [CNT_W-1:0]       x_q, x_n, y_q, y_n, bcnt_q, bcnt_n;
    logic [SUB_W-1:0]       sub_q, sub_n;
    logic [FRAME_W-1:0]     frame_q, frame_n;
    logic [DATA_WIDTH-1:0]  do_q, do_n, pix_c;
    logic                   de_q, de_n, hs_q, hs_n, vs_q, vs_n, fd_q, fd_n;
    logic                   start;
    logic                   cfg_empty_c;

    assign cfg_in_c    = '{width:  cfg_width_i,  height: cfg_height_i,
                           hblank: cfg_hblank_i, vblank: cfg_vblank_i,
                           pat:    pat_sel_e'(pattern_sel_i)};
    assign cfg_empty_c = (cfg_width_i == '0) || (cfg_height_i == '0);

    vid_pattern_lut #(.DATA_WIDTH(DATA_WIDTH)) u_lut (
        .sel   (cfg_q.pat),
        .x     (x_q),
        .y     (y_q),
        .f     (frame_q),
        .pix_c (pix_c)
    );

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bcnt_q  <= '0;
            sub_q   <= '0;
            frame_q <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cfg_q   <= cfg_n;
            x_q     <= x_n;
            y_q     <= y_n;
            bcnt_q  <= bcnt_n;
            sub_q   <= sub_n;
            frame_q <= frame_n;
            do_q    <= do_n;
            de_q    <= de_n;
            hs_q    <= hs_n;
            vs_q    <= vs_n;
            fd_q    <= fd_n;
        end
    end

    // Next state, counters and next output values.
    always_comb begin
        state_n = state_q;
        cfg_n   = cfg_q;
        x_n     = x_q;
        y_n     = y_q;
        bcnt_n  = bcnt_q;
        sub_n   = sub_q;
        frame_n = frame_q;
        do_n    = do_q;
        de_n    = 1'b0;
        hs_n    = 1'b1;
        vs_n    = 1'b1;
        fd_n    = 1'b0;
        start   = 1'b0;

        case (state_q)
            IDLE: start = enable_i;
            LINE: begin
                hs_n = 1'b0;
                vs_n = 1'b0;
                // Pixel is presented only in the last cycle of its slot.
                if (sub_q == SUB_LAST) begin
                    de_n  = 1'b1;
                    do_n  = pix_c;
                    sub_n = '0;
                    if (x_q == cfg_q.width - CNT_W'(1)) begin
                        x_n = '0;
                        if (y_q == cfg_q.height - CNT_W'(1)) begin
                            fd_n    = 1'b1;
                            frame_n = frame_q + FRAME_W'(1);
                            state_n = VBLANK;
                            bcnt_n  = blank_load(cfg_q.vblank);
                        end else begin
                            state_n = HBLANK;
                            bcnt_n  = blank_load(cfg_q.hblank);
                        end
                    end else begin
                        x_n = x_q + CNT_W'(1);
                    end
                end else begin
                    sub_n = sub_q + SUB_W'(1);
                end
            end
            HBLANK: begin
                vs_n = 1'b0;
                if (bcnt_q == '0) begin
                    state_n = LINE;
                    y_n     = y_q + CNT_W'(1);
                end else begin
                    bcnt_n = bcnt_q - CNT_W'(1);
                end
            end
            VBLANK: begin
                if (bcnt_q == '0) begin
                    if (enable_i) start   = 1'b1;
                    else          state_n = IDLE;
                end else begin
                    bcnt_n = bcnt_q - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame start: capture config; an empty frame goes straight to VBLANK.
        if (start) begin
            cfg_n = cfg_in_c;
            x_n   = '0;
            y_n   = '0;
            sub_n = '0;
            if (cfg_empty_c) begin
                state_n = VBLANK;
                bcnt_n  = blank_load(cfg_vblank_i);
            end else begin
                state_n = LINE;
            end
        end
    end

    assign vid.do_o         = do_q;
    assign vid.de_o         = de_q;
    assign vid.hs_o         = hs_q;
    assign vid.vs_o         = vs_q;
    assign vid.frame_done_o = fd_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen: timing, patterns, config latching,
// enable drop, empty frames, mid-slot reset and sparse output.
module tb_vid_pattern_gen;

    localparam int S_DE = 0, S_HS = 1, S_VS = 2, S_FD = 3, S_DE3 = 4, S_HS3 = 5;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        en0, en3;
    logic [15:0] cfg_w, cfg_h, cfg_hb, cfg_vb;
    logic [1:0]  sel;

    int vectors     = 0;
    int miscompares = 0;

    logic       de_a  [DEPTH];
    logic       hs_a  [DEPTH];
    logic       vs_a  [DEPTH];
    logic       fd_a  [DEPTH];
    logic [7:0] do_a  [DEPTH];
    logic       de3_a [DEPTH];
    logic       hs3_a [DEPTH];
    logic [7:0] do3_a [DEPTH];
    logic [7:0] pix_q [$];

    vid_pattern_gen_if #(.DATA_WIDTH(8)) vif0 ();
    vid_pattern_gen_if #(.DATA_WIDTH(8)) vif3 ();

    vid_pattern_gen #(.DATA_WIDTH(8), .SPARSE_OUTPUT(0)) dut0 (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (en0),
        .cfg_width_i   (cfg_w),
        .cfg_height_i  (cfg_h),
        .cfg_hblank_i  (cfg_hb),
        .cfg_vblank_i  (cfg_vb),
        .pattern_sel_i (sel),
        .vid           (vif0)
    );

    vid_pattern_gen #(.DATA_WIDTH(8), .SPARSE_OUTPUT(3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (en3),
        .cfg_width_i   (cfg_w),
        .cfg_height_i  (cfg_h),
        .cfg_hblank_i  (cfg_hb),
        .cfg_vblank_i  (cfg_vb),
        .pattern_sel_i (sel),
        .vid           (vif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample both DUTs at each falling edge into the trace arrays.
    task automatic trace(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            @(negedge clk);
            de_a[i]  = vif0.de_o;
            hs_a[i]  = vif0.hs_o;
            vs_a[i]  = vif0.vs_o;
            fd_a[i]  = vif0.frame_done_o;
            do_a[i]  = vif0.do_o;
            de3_a[i] = vif3.de_o;
            hs3_a[i] = vif3.hs_o;
            do3_a[i] = vif3.do_o;
            if (vif0.de_o) pix_q.push_back(vif0.do_o);
        end
    endtask

    function automatic int cnt(input int s, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (s)
                S_DE:    n += de_a[i]  ? 1 : 0;
                S_HS:    n += hs_a[i]  ? 1 : 0;
                S_VS:    n += vs_a[i]  ? 1 : 0;
                S_FD:    n += fd_a[i]  ? 1 : 0;
                S_DE3:   n += de3_a[i] ? 1 : 0;
                S_HS3:   n += hs3_a[i] ? 1 : 0;
                default: n += 0;
            endcase
        end
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        en0 = 1'b0;
        en3 = 1'b0;
        pix_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int vb, input int s);
        cfg_w  = 16'(w);
        cfg_h  = 16'(h);
        cfg_hb = 16'(hb);
        cfg_vb = 16'(vb);
        sel    = 2'(s);
    endtask

    initial begin
        rst = 1'b0;
        en0 = 1'b0;
        en3 = 1'b0;
        set_cfg(4, 2, 3, 5, 0);

        // Reset values
        @(negedge clk);
        check_vec("rst_de", 32'(vif0.de_o), 32'd0);
        check_vec("rst_hs", 32'(vif0.hs_o), 32'd1);
        check_vec("rst_vs", 32'(vif0.vs_o), 32'd1);
        check_vec("rst_do", 32'(vif0.do_o), 32'd0);
        check_vec("rst_fd", 32'(vif0.frame_done_o), 32'd0);

        // Basic timing: W=4 H=2 hblank=3 vblank=5, horizontal ramp
        do_reset();
        set_cfg(4, 2, 3, 5, 0);
        en0 = 1'b1;
        trace(0, 40);
        check_vec("lat_t0_de", 32'(de_a[0]), 32'd0);
        check_vec("lat_t1_de", 32'(de_a[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_vec("line0_px", 32'(do_a[1 + i]), 32'(i));
            check_vec("line1_px", 32'(do_a[8 + i]), 32'(i));
        end
        check_vec("hb_hs_cnt", 32'(cnt(S_HS, 1, 11)), 32'd3);
        check_vec("hb_hs_t5", 32'(hs_a[5]), 32'd1);
        check_vec("hb_vs_t6", 32'(vs_a[6]), 32'd0);
        check_vec("vb_cnt", 32'(cnt(S_VS, 1, 16)), 32'd5);
        check_vec("vb_t12", 32'(vs_a[12]), 32'd1);
        check_vec("vb_end", 32'(vs_a[17]), 32'd0);
        check_vec("de_per_frame", 32'(cnt(S_DE, 1, 16)), 32'd8);
        check_vec("fd_t11", 32'(fd_a[11]), 32'd1);
        check_vec("fd_t27", 32'(fd_a[27]), 32'd1);
        check_vec("fd_cnt", 32'(cnt(S_FD, 0, 39)), 32'd2);

        // Width change mid-frame applies only to the next frame
        do_reset();
        set_cfg(4, 2, 1, 1, 0);
        en0 = 1'b1;
        trace(0, 3);
        cfg_w = 16'd8;
        trace(3, 40);
        check_vec("cfg_f0_de", 32'(cnt(S_DE, 1, 10)), 32'd8);
        check_vec("cfg_f0_fd", 32'(fd_a[9]), 32'd1);
        check_vec("cfg_f1_de", 32'(cnt(S_DE, 11, 28)), 32'd16);
        check_vec("cfg_f1_px7", 32'(do_a[18]), 32'd7);
        check_vec("cfg_f1_hb", 32'(hs_a[19]), 32'd1);
        check_vec("cfg_f1_fd", 32'(fd_a[27]), 32'd1);

        // Enable dropped during line 0: frame completes, then idle
        do_reset();
        set_cfg(4, 2, 3, 5, 0);
        en0 = 1'b1;
        trace(0, 3);
        en0 = 1'b0;
        trace(3, 60);
        check_vec("drop_de", 32'(cnt(S_DE, 0, 62)), 32'd8);
        check_vec("drop_fd", 32'(cnt(S_FD, 0, 62)), 32'd1);
        check_vec("drop_hs", 32'(cnt(S_HS, 12, 62)), 32'd51);
        check_vec("drop_vs", 32'(cnt(S_VS, 12, 62)), 32'd51);

        // Zero height: permanent blanking, no frame_done
        do_reset();
        set_cfg(4, 0, 3, 2, 0);
        en0 = 1'b1;
        trace(0, 60);
        check_vec("h0_de", 32'(cnt(S_DE, 0, 59)), 32'd0);
        check_vec("h0_vs", 32'(cnt(S_VS, 0, 59)), 32'd60);
        check_vec("h0_hs", 32'(cnt(S_HS, 0, 59)), 32'd60);
        check_vec("h0_fd", 32'(cnt(S_FD, 0, 59)), 32'd0);

        // Asynchronous reset inside a pixel slot, then restart at x=0, y=0
        do_reset();
        set_cfg(4, 2, 3, 5, 0);
        en0 = 1'b1;
        trace(0, 3);
        check_vec("pre_rst_de", 32'(de_a[2]), 32'd1);
        check_vec("pre_rst_do", 32'(do_a[2]), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_vec("arst_de", 32'(vif0.de_o), 32'd0);
        check_vec("arst_hs", 32'(vif0.hs_o), 32'd1);
        check_vec("arst_vs", 32'(vif0.vs_o), 32'd1);
        check_vec("arst_do", 32'(vif0.do_o), 32'd0);
        @(negedge clk);
        sel = 2'd3;
        en0 = 1'b0;
        rst = 1'b1;
        trace(0, 5);
        check_vec("idle_de", 32'(cnt(S_DE, 0, 4)), 32'd0);
        check_vec("idle_hs", 32'(cnt(S_HS, 0, 4)), 32'd5);
        en0 = 1'b1;
        trace(0, 12);
        check_vec("rs_t1_de", 32'(de_a[1]), 32'd1);
        check_vec("rs_x0y0", 32'(do_a[1]), 32'd0);
        check_vec("rs_x1y0", 32'(do_a[2]), 32'd1);
        check_vec("rs_x0y1", 32'(do_a[8]), 32'd1);

        // Checker pattern: 16x9
        do_reset();
        set_cfg(16, 9, 1, 1, 2);
        en0 = 1'b1;
        trace(0, 160);
        check_vec("chk_x0y0", 32'(pix_q[0]), 32'd0);
        check_vec("chk_x7y0", 32'(pix_q[7]), 32'd0);
        check_vec("chk_x8y0", 32'(pix_q[8]), 32'd255);
        check_vec("chk_x15y0", 32'(pix_q[15]), 32'd255);
        check_vec("chk_x0y8", 32'(pix_q[128]), 32'd255);
        check_vec("chk_x8y8", 32'(pix_q[136]), 32'd0);

        // Diagonal pattern across two frames
        do_reset();
        set_cfg(4, 2, 1, 1, 3);
        en0 = 1'b1;
        trace(0, 25);
        check_vec("diag_f0_x1y1", 32'(pix_q[5]), 32'd2);
        check_vec("diag_f1_x0y0", 32'(pix_q[8]), 32'd1);
        check_vec("diag_f1_x3y1", 32'(pix_q[15]), 32'd5);

        // Frame counter wrap 255 -> 0 seen through the diagonal pattern
        do_reset();
        set_cfg(1, 1, 1, 1, 3);
        en0 = 1'b1;
        trace(0, 600);
        check_vec("wrap_f1", 32'(pix_q[1]), 32'd1);
        check_vec("wrap_f255", 32'(pix_q[255]), 32'd255);
        check_vec("wrap_f256", 32'(pix_q[256]), 32'd0);

        // Sparse output: slot of 4 cycles, W=3
        do_reset();
        set_cfg(3, 1, 1, 2, 0);
        en3 = 1'b1;
        trace(0, 20);
        check_vec("sp_t3_de", 32'(de3_a[3]), 32'd0);
        check_vec("sp_t4_de", 32'(de3_a[4]), 32'd1);
        check_vec("sp_t8_de", 32'(de3_a[8]), 32'd1);
        check_vec("sp_t12_de", 32'(de3_a[12]), 32'd1);
        check_vec("sp_de_cnt", 32'(cnt(S_DE3, 0, 15)), 32'd3);
        check_vec("sp_hs_line", 32'(cnt(S_HS3, 1, 12)), 32'd0);
        check_vec("sp_px1", 32'(do3_a[8]), 32'd1);
        check_vec("sp_hold", 32'(do3_a[10]), 32'd1);
        check_vec("sp_px2", 32'(do3_a[12]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vid_pattern_gen.md
VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter SPARSE_OUTPUT, default 0: empty cycles per pixel slot; each slot is SPARSE_OUTPUT+1 cycles long.
REQ-003 SHALL have ports (name, direction, width, meaning), in this order:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous and active-low.
- enable_i  in  1  run request.
- cfg_width_i  in  16  active pixels per line.
- cfg_height_i  in  16  lines per frame.
- cfg_hblank_i  in  16  cycles between lines.
- cfg_vblank_i  in  16  cycles between frames.
- pattern_sel_i  in  2  test pattern select.
- do_o  out  DATA_WIDTH  pixel data.
- de_o  out  1  pixel valid.
- hs_o  out  1  high outside active line.
- vs_o  out  1  high outside active frame.
- frame_done_o  out  1  one-cycle pulse at the end of each frame.

Function
REQ-004 SHALL implement an FSM with states IDLE, LINE, HBLANK and VBLANK; all outputs SHALL be registered.
REQ-005 IDLE: de_o=0, hs_o=1, vs_o=1; if enable_i=1 at a clock edge, latch all cfg_* and pattern_sel_i, clear x and y, and go to LINE.
REQ-006 LINE: hs_o=0, vs_o=0; emit cfg_width pixels; de_o=1 only in the last cycle of each slot, with do_o valid in that cycle; do_o holds its value in other cycles.
REQ-007 After the last pixel of a line that is not the last line: go to HBLANK, with hs_o=1, vs_o=0, de_o=0, for max(cfg_hblank,1) cycles, then return to LINE with y+1.
REQ-008 After the last pixel of the last line: pulse frame_done_o for one cycle, increment the 8-bit frame counter (wraps 255->0), and go to VBLANK.
REQ-009 VBLANK: hs_o=1, vs_o=1, de_o=0, for max(cfg_vblank,1) cycles. At its end, if enable_i=1, re-latch the config and go to LINE; otherwise go to IDLE.
REQ-010 Config latching: cfg_* and pattern_sel_i SHALL be sampled only at frame start; changes mid-frame SHALL have no effect on the current frame.
REQ-011 If the latched cfg_width=0 or cfg_height=0: SHALL go to VBLANK with no LINE state and no frame_done_o pulse.
REQ-012 enable_i deasserted mid-frame: the current frame SHALL complete, including its VBLANK, then the block goes to IDLE.
REQ-013 Patterns, with p=(x,y,f) truncated to DATA_WIDTH:
- 0: x (horizontal ramp).
- 1: y (vertical ramp).
- 2: all-ones if x[3]^y[3], else 0 (checker).
- 3: x+y+f (moving diagonal).
REQ-014 Latency: with enable_i sampled in IDLE at edge k, the first de_o=1 SHALL be visible after edge k+1+SPARSE_OUTPUT.
REQ-015 x and y counters SHALL be 16 bits; x counts slots within a line; y counts lines within a frame.

Reset
REQ-016 While rst=0: state=IDLE, de_o=0, hs_o=1, vs_o=1, do_o=0, frame_done_o=0, and x, y and frame counter cleared.
REQ-017 Reset asserted mid-line SHALL force IDLE outputs immediately, without waiting for a clock edge.
REQ-018 After rst releases, the block SHALL start only on enable_i=1.

Structure
REQ-019 The shared video package SHALL hold the FSM state enum and pattern_sel encodings (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_DIAG).
REQ-020 Pattern generation SHALL be a combinational sub-module vid_pattern_lut; the FSM, counters and output registers stay in vid_pattern_gen.

Verification
REQ-021 With W=4, H=2, hblank=3, vblank=5, SPARSE=0, pattern 0: the bench SHALL see do_o 0,1,2,3 on consecutive de_o cycles per line, hs_o=1 for 3 cycles between lines, vs_o=1 for 5 cycles, and a frame period of 16 cycles.
REQ-022 With SPARSE_OUTPUT=3 and W=3: de_o SHALL pulse every 4th cycle, 3 pulses per line, with hs_o=0 throughout the line.
REQ-023 Changing cfg_width_i from 4 to 8 mid-frame: the current frame SHALL keep 4 pixels per line and the next frame SHALL have 8.
REQ-024 Dropping enable_i during line 0 of H=2: the bench SHALL see both lines, one frame_done_o pulse, then IDLE with hs_o=1, vs_o=1 indefinitely.
REQ-025 cfg_height_i=0 with enable_i held high: de_o SHALL never assert, vs_o SHALL stay 1, and frame_done_o SHALL stay 0.
REQ-026 rst pulled low during a pixel slot: outputs SHALL reach reset values before the next clk edge, and the generator SHALL restart at x=0, y=0 after release.
